vga_sync_controller: RTL

Sequences the VGA scan: horizontal and vertical pixel counters advance on a pixel-rate strobe and produce hsync, vsync, the active-video flag and pixel coordinates for the pixel generator. It sits between the pixel-clock divider, whose output edge supplies `pix_en`, and the colour and output logic. A small run/stop state machine starts scanning on request and stops only at a frame boundary, so the monitor never sees a truncated frame.

---
 rtl/vga_sync_controller.sv | 109 ++++++++++
 1 files changed

// File: rtl/vga_sync_controller.sv
// rtl/vga_sync_controller.sv - VGA horizontal/vertical scan sequencer with run/stop control
module vga_sync_controller #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_ACT = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    input  logic       enable,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       line_start,
    output logic       frame_start,
    output logic       running
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] X_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] X_VIS_END  = 10'(H_ACTIVE);
    localparam logic [9:0] Y_VIS_END  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        STOP_PEND = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic active;
    logic x_last;
    logic y_last;
    logic wrap_x;
    logic wrap_frame;
    logic in_hs;
    logic in_vs;

    assign active     = (state != IDLE);
    assign x_last     = (x == X_LAST);
    assign y_last     = (y == Y_LAST);
    assign wrap_x     = active && pix_en && x_last;
    assign wrap_frame = wrap_x && y_last;
    assign in_hs      = (x >= HS_START) && (x < HS_END);
    assign in_vs      = (y >= VS_START) && (y < VS_END);
    assign running    = active;

    // A re-raised enable in STOP_PEND wins over the frame-end halt.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (enable) state_next = RUN;
            RUN:       if (!enable) state_next = STOP_PEND;
            STOP_PEND: begin
                if (enable)          state_next = RUN;
                else if (wrap_frame) state_next = IDLE;
            end
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            x <= '0;
            y <= '0;
        end else if (active && pix_en) begin
            x <= x_last ? '0 : x + 10'd1;
            if (x_last) y <= y_last ? '0 : y + 10'd1;
        end
    end

    // Decodes are taken from the pre-edge counters, so they trail x/y by one clk.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hsync       <= ~SYNC_ACT;
            vsync       <= ~SYNC_ACT;
            video_on    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= (active && in_hs) ? SYNC_ACT : ~SYNC_ACT;
            vsync       <= (active && in_vs) ? SYNC_ACT : ~SYNC_ACT;
            video_on    <= active && (x < X_VIS_END) && (y < Y_VIS_END);
            line_start  <= wrap_x;
            frame_start <= wrap_frame || (state == IDLE && enable);
        end
    end
endmodule
